// File: rtl/spi_frontend_sync.sv
// spi_frontend_sync: SPI slave front end. Synchronizes the raw sck/sdi/cs pins
// into the clk domain and decodes the mode-dependent sample/shift edges. It also
// produces frame pulses and assembles MSB-first words.
// Optional feature: define SPI_FRONTEND_GLITCH_FILTER_EN to add a per-channel
// glitch filter. With the filter, a synchronized level must persist for
// FILTER_LEN samples before the *_out level follows it.
module spi_frontend_sync #(
    parameter int SYNC_STAGES = 2,
    parameter int WORD_BITS   = 8,
    parameter int FILTER_LEN  = 3
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         sck,
    input  logic                         sdi,
    input  logic                         cs,
    input  logic [1:0]                   mode,
    output logic                         sck_out,
    output logic                         sdi_out,
    output logic                         cs_out,
    output logic                         sample_strobe,
    output logic                         shift_strobe,
    output logic                         frame_start,
    output logic                         frame_end,
    output logic [$clog2(WORD_BITS)-1:0] bit_count,
    output logic                         word_valid,
    output logic [WORD_BITS-1:0]         word
);

    localparam int CW = $clog2(WORD_BITS);
    localparam int CH = 3;
    // Channel order {cs, sdi, sck}; cs idles high (deselected).
    localparam logic [CH-1:0] IDLE_LVL = 3'b100;

    if (SYNC_STAGES < 2 || WORD_BITS < 2 || WORD_BITS > 32 ||
        FILTER_LEN < 2 || FILTER_LEN > 15) begin : g_param_check
        $error("spi_frontend_sync: parameter out of range");
    end

    logic [CH-1:0] pin_s;
    logic [CH-1:0] out_s;
    logic [CH-1:0] hist_r;
    logic [CH-1:0] rise_s;
    logic [CH-1:0] fall_s;
    logic [1:0]    mode_r;

    assign pin_s = {cs, sdi, sck};

    for (genvar g = 0; g < CH; g++) begin : g_ch
        logic [SYNC_STAGES-1:0] chain_r;

        // Metastability chain for one pin
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                chain_r <= {SYNC_STAGES{IDLE_LVL[g]}};
            end else begin
                chain_r <= {chain_r[SYNC_STAGES-2:0], pin_s[g]};
            end
        end

`ifdef SPI_FRONTEND_GLITCH_FILTER_EN
        logic [3:0] cnt_r;
        logic       filt_r;

        // Follow the synchronized level only after FILTER_LEN differing samples in a row
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                cnt_r  <= 4'd0;
                filt_r <= IDLE_LVL[g];
            end else if (chain_r[SYNC_STAGES-1] == filt_r) begin
                cnt_r  <= 4'd0;
            end else if (cnt_r == 4'(FILTER_LEN - 1)) begin
                cnt_r  <= 4'd0;
                filt_r <= chain_r[SYNC_STAGES-1];
            end else begin
                cnt_r  <= cnt_r + 4'd1;
            end
        end

        assign out_s[g] = filt_r;
`else
        assign out_s[g] = chain_r[SYNC_STAGES-1];
`endif
    end

    assign sck_out = out_s[0];
    assign sdi_out = out_s[1];
    assign cs_out  = out_s[2];

    // One-cycle history of each output level, used for edge detection
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hist_r <= IDLE_LVL;
        end else begin
            hist_r <= out_s;
        end
    end

    // Mode is latched while deselected and frozen for the duration of a frame
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mode_r <= 2'b00;
        end else if (cs_out) begin
            mode_r <= mode;
        end else begin
            mode_r <= mode_r;
        end
    end

    assign rise_s = out_s & ~hist_r;
    assign fall_s = ~out_s & hist_r;

    logic lead_s;
    logic trail_s;

    // Map sck edges to leading/trailing, then to sample/shift; gate with the chip select
    always_comb begin
        lead_s        = 1'b0;
        trail_s       = 1'b0;
        sample_strobe = 1'b0;
        shift_strobe  = 1'b0;
        if (mode_r[1]) begin
            lead_s  = fall_s[0];
            trail_s = rise_s[0];
        end else begin
            lead_s  = rise_s[0];
            trail_s = fall_s[0];
        end
        if (mode_r[0]) begin
            sample_strobe = trail_s & ~cs_out;
            shift_strobe  = lead_s & ~cs_out;
        end else begin
            sample_strobe = lead_s & ~cs_out;
            shift_strobe  = trail_s & ~cs_out;
        end
    end

    assign frame_start = fall_s[2];
    assign frame_end   = rise_s[2];

    logic [WORD_BITS-1:0] shift_r;
    logic [WORD_BITS-1:0] shift_n;
    logic [WORD_BITS-1:0] word_r;
    logic [WORD_BITS-1:0] word_n;
    logic [CW-1:0]        count_r;
    logic [CW-1:0]        count_n;
    logic                 valid_r;
    logic                 valid_n;

    // Word assembly: clearing at a frame boundary happens before a coincident sample is applied
    always_comb begin
        shift_n = shift_r;
        count_n = count_r;
        word_n  = word_r;
        valid_n = 1'b0;
        if (frame_start || frame_end) begin
            shift_n = {WORD_BITS{1'b0}};
            count_n = {CW{1'b0}};
        end else begin
            shift_n = shift_r;
            count_n = count_r;
        end
        if (sample_strobe) begin
            if (count_n == CW'(WORD_BITS - 1)) begin
                word_n  = {shift_n[WORD_BITS-2:0], sdi_out};
                valid_n = 1'b1;
                shift_n = {WORD_BITS{1'b0}};
                count_n = {CW{1'b0}};
            end else begin
                shift_n = {shift_n[WORD_BITS-2:0], sdi_out};
                count_n = count_n + CW'(1);
            end
        end else begin
            word_n = word_r;
        end
    end

    // Word assembly state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shift_r <= {WORD_BITS{1'b0}};
            count_r <= {CW{1'b0}};
            word_r  <= {WORD_BITS{1'b0}};
            valid_r <= 1'b0;
        end else begin
            shift_r <= shift_n;
            count_r <= count_n;
            word_r  <= word_n;
            valid_r <= valid_n;
        end
    end

    assign bit_count  = count_r;
    assign word       = word_r;
    assign word_valid = valid_r;

endmodule

// File: tb/tb_spi_frontend_sync.sv
// Testbench for spi_frontend_sync (default parameters).
module tb_spi_frontend_sync;

    localparam int H = 4;   // SPI half period in clk cycles
`ifdef SPI_FRONTEND_GLITCH_FILTER_EN
    localparam int LAT = 2 + 3;
`else
    localparam int LAT = 2;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       sck = 1'b0;
    logic       sdi = 1'b0;
    logic       cs = 1'b1;
    logic [1:0] mode_in = 2'b00;
    logic       sck_out, sdi_out, cs_out;
    logic       sample_strobe, shift_strobe, frame_start, frame_end;
    logic [2:0] bit_count;
    logic       word_valid;
    logic [7:0] word;

    spi_frontend_sync dut (
        .clk(clk), .reset(reset), .sck(sck), .sdi(sdi), .cs(cs), .mode(mode_in),
        .sck_out(sck_out), .sdi_out(sdi_out), .cs_out(cs_out),
        .sample_strobe(sample_strobe), .shift_strobe(shift_strobe),
        .frame_start(frame_start), .frame_end(frame_end),
        .bit_count(bit_count), .word_valid(word_valid), .word(word)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Monitor state (written only by the monitor)
    int         smp_cnt = 0, shf_cnt = 0, fs_cnt = 0, fe_cnt = 0, lvl_bad = 0;
    logic [7:0] got_q[$];
    logic [1:0] cur_mode = 2'b00;

    always @(negedge clk) begin
        if (!reset) begin
            if (sample_strobe) begin
                smp_cnt++;
                // sampling happens on sck rise when CPOL == CPHA, on fall otherwise
                if (sck_out !== (cur_mode[1] == cur_mode[0])) begin
                    lvl_bad++;
                    $display("note: sample strobe at sck level %b, mode %b", sck_out, cur_mode);
                end
            end
            if (shift_strobe) begin
                shf_cnt++;
                if (sck_out !== (cur_mode[1] != cur_mode[0])) begin
                    lvl_bad++;
                    $display("note: shift strobe at sck level %b, mode %b", sck_out, cur_mode);
                end
            end
            if (frame_start) fs_cnt++;
            if (frame_end)   fe_cnt++;
            if (word_valid)  got_q.push_back(word);
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    typedef struct {
        logic [1:0]  mode;
        int          nbits;
        logic [31:0] data;
        bit          chg_mode;
        int          exp_nw;     // completed words
        logic [7:0]  exp_word;   // word output after the frame
        int          exp_bc;     // bit_count just before cs rises
    } vec_t;

    logic [7:0] last_word = 8'h00;

    task automatic run_frame(input logic [1:0] m, input int nbits, input logic [31:0] data,
                             input bit chg, input int exp_nw, input logic [7:0] exp_word,
                             input int exp_bc, input string name);
        int s_smp, s_shf, s_fs, s_fe, s_q, s_lvl, avail;
        logic [31:0] dv;
        s_smp = smp_cnt; s_shf = shf_cnt; s_fs = fs_cnt; s_fe = fe_cnt;
        s_q = got_q.size(); s_lvl = lvl_bad;
        dv = data;
        cur_mode = m;
        mode_in = m;
        sck = m[1];
        cs = 1'b1;
        repeat (2 * H) @(negedge clk);
        cs = 1'b0;
        repeat (H) @(negedge clk);
        for (int i = nbits - 1; i >= 0; i--) begin
            if (chg && i == nbits / 2) mode_in = ~m;
            if (!m[0]) begin
                sdi = dv[i];
                repeat (H) @(negedge clk);
                sck = ~m[1];
                repeat (H) @(negedge clk);
                sck = m[1];
            end else begin
                sck = ~m[1];
                sdi = dv[i];
                repeat (H) @(negedge clk);
                sck = m[1];
                repeat (H) @(negedge clk);
            end
        end
        repeat (H + LAT + 2) @(negedge clk);
        chk({name, " bit_count_in_frame"}, 32'(bit_count), 32'(exp_bc));
        cs = 1'b1;
        repeat (H + LAT + 2) @(negedge clk);
        chk({name, " samples"}, 32'(smp_cnt - s_smp), 32'(nbits));
        chk({name, " shifts"}, 32'(shf_cnt - s_shf), 32'(nbits));
        chk({name, " frame_start"}, 32'(fs_cnt - s_fs), 32'd1);
        chk({name, " frame_end"}, 32'(fe_cnt - s_fe), 32'd1);
        chk({name, " strobe_levels"}, 32'(lvl_bad - s_lvl), 32'd0);
        chk({name, " nwords"}, 32'(got_q.size() - s_q), 32'(exp_nw));
        avail = got_q.size() - s_q;
        for (int k = 0; k < exp_nw && k < avail; k++)
            chk({name, " word_k"}, 32'(got_q[s_q + k]),
                (dv >> (nbits - 8 * (k + 1))) & 32'h0000_00FF);
        chk({name, " word_hold"}, 32'(word), 32'(exp_word));
        chk({name, " bit_count_idle"}, 32'(bit_count), 32'd0);
        last_word = exp_word;
    endtask

    vec_t tbl[7];

    initial begin
        int n_lat, rises;
        logic prev;
        tbl[0] = '{2'b00,  8, 32'h0000_00A5, 1'b0, 1, 8'hA5, 0};
        tbl[1] = '{2'b11,  8, 32'h0000_003C, 1'b1, 1, 8'h3C, 0};
        tbl[2] = '{2'b01,  8, 32'h0000_00C3, 1'b0, 1, 8'hC3, 0};
        tbl[3] = '{2'b10,  8, 32'h0000_007E, 1'b0, 1, 8'h7E, 0};
        tbl[4] = '{2'b00, 16, 32'h0000_1234, 1'b0, 2, 8'h34, 0};
        tbl[5] = '{2'b00,  5, 32'h0000_001B, 1'b0, 0, 8'h34, 5};
        tbl[6] = '{2'b10, 12, 32'h0000_0ABC, 1'b1, 1, 8'hAB, 4};

        // reset state
        repeat (3) @(negedge clk);
        chk("rst cs_out", 32'(cs_out), 32'd1);
        chk("rst sck_out", 32'(sck_out), 32'd0);
        chk("rst word", 32'(word), 32'd0);
        chk("rst bit_count", 32'(bit_count), 32'd0);
        chk("rst pulses", 32'({sample_strobe, shift_strobe, frame_start, frame_end, word_valid}), 32'd0);
        reset = 1'b0;
        repeat (6) @(negedge clk);
        chk("release no frame pulses", 32'(fs_cnt + fe_cnt), 32'd0);

        // pin-to-output latency
        sdi = 1'b1;
        n_lat = 0;
        for (int n = 1; n <= LAT + 4 && n_lat == 0; n++) begin
            @(posedge clk); #1;
            if (sdi_out === 1'b1) n_lat = n;
        end
        chk("sdi latency", 32'(n_lat), 32'(LAT));
        sdi = 1'b0;
        repeat (LAT + 2) @(negedge clk);

`ifdef SPI_FRONTEND_GLITCH_FILTER_EN
        // glitch filtering on sck while deselected
        rises = 0; prev = sck_out;
        sck = 1'b1; repeat (2) @(negedge clk); sck = 1'b0;
        for (int n = 0; n < 12; n++) begin
            @(negedge clk); if (sck_out && !prev) rises++; prev = sck_out;
        end
        chk("glitch2 ignored", 32'(rises), 32'd0);
        sck = 1'b1; repeat (3) @(negedge clk); sck = 1'b0;
        for (int n = 0; n < 12; n++) begin
            @(negedge clk); if (sck_out && !prev) rises++; prev = sck_out;
        end
        chk("pulse3 passes", 32'(rises), 32'd1);
`else
        rises = 0; prev = 1'b0;
`endif

        // table-driven frames
        for (int t = 0; t < 7; t++)
            run_frame(tbl[t].mode, tbl[t].nbits, tbl[t].data, tbl[t].chg_mode,
                      tbl[t].exp_nw, tbl[t].exp_word, tbl[t].exp_bc, $sformatf("tbl%0d", t));

        // randomized frames against the word model
        for (int r = 0; r < 8; r++) begin
            logic [1:0]  m;
            int          nb, nw;
            logic [31:0] d;
            logic [7:0]  ew;
            m  = 2'($urandom_range(0, 3));
            nb = $urandom_range(1, 24);
            d  = $urandom & ((32'h1 << nb) - 32'h1);
            nw = nb / 8;
            ew = (nw > 0) ? 8'((d >> (nb - 8 * nw)) & 32'hFF) : last_word;
            run_frame(m, nb, d, 1'($urandom_range(0, 1)), nw, ew, nb % 8, $sformatf("rnd%0d", r));
        end

        // reset in the middle of a frame
        mode_in = 2'b00; cur_mode = 2'b00; sck = 1'b0; cs = 1'b0;
        repeat (H + LAT) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            sdi = 1'($urandom_range(0, 1));
            repeat (H) @(negedge clk); sck = 1'b1;
            repeat (H) @(negedge clk); sck = 1'b0;
        end
        repeat (LAT + 2) @(negedge clk);
        chk("pre-reset bit_count", 32'(bit_count), 32'd4);
        reset = 1'b1;
        #1;
        chk("midreset cs_out", 32'(cs_out), 32'd1);
        chk("midreset outputs", 32'({sck_out, sdi_out, sample_strobe, shift_strobe,
                                     frame_start, frame_end, word_valid}), 32'd0);
        chk("midreset word/count", 32'({word, bit_count}), 32'd0);
        cs = 1'b1; sck = 1'b0; sdi = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        last_word = 8'h00;
        run_frame(2'b00, 8, 32'h0000_005A, 1'b0, 1, 8'h5A, 0, "after_reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
